// File: rtl/da_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : da_rom_loader
//  Purpose  : Writer side of the DA FIR partial-sum ROM. Collects NTAPS signed
//             coefficients over a valid/ready stream, then writes every one of
//             the 2^NTAPS partial sums into the ROM (active-low CEN/WEN) while
//             holding CLOAD high toward the DA controller.
//  Ports    : clk, resetn        - clock, synchronous active-low reset
//             coef_in_i          - signed coefficient (first accepted = coef[0])
//             coef_valid_i       - coefficient valid
//             coef_ready_o       - loader can accept a coefficient
//             cload_o            - high while ROM writes are in progress
//             rom_cen_o/wen_o    - ROM chip/write enable, active-low
//             rom_addr_o/rom_d_o - ROM write address / write data
//             busy_o             - high whenever the loader is not idle
//             load_done_o        - one-cycle pulse after the last ROM write
//  Revision : 1.0 - initial release
// ============================================================================
module da_rom_loader #(
    parameter int NTAPS = 4,
    parameter int CW    = 8,
    parameter int DW    = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [CW-1:0]    coef_in_i,
    input  logic             coef_valid_i,
    output logic             coef_ready_o,
    output logic             cload_o,
    output logic             rom_cen_o,
    output logic             rom_wen_o,
    output logic [NTAPS-1:0] rom_addr_o,
    output logic [DW-1:0]    rom_d_o,
    output logic             busy_o,
    output logic             load_done_o
);

    localparam int               CNT_W     = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NTAPS - 1);
    localparam logic [NTAPS-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]     coef_q [NTAPS];
    logic [CW-1:0]     coef_d [NTAPS];
    logic              ready_q, ready_d;
    logic              cload_q, cload_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [NTAPS-1:0]  addr_q, addr_d;
    logic [DW-1:0]     romd_q, romd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Partial sum for the address that will be presented next cycle during
    // WRITE. Each set address bit selects the matching coefficient,
    // sign-extended to DW before accumulation so the sum cannot overflow.
    logic [NTAPS-1:0]  next_addr;
    logic [DW-1:0]     next_sum;

    assign next_addr = addr_q + NTAPS'(1);

    always_comb begin
        next_sum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (next_addr[i]) begin
                next_sum = next_sum + {{(DW-CW){coef_q[i][CW-1]}}, coef_q[i]};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        coef_d  = coef_q;
        ready_d = 1'b0;
        cload_d = 1'b0;
        cen_d   = 1'b1;
        wen_d   = 1'b1;
        addr_d  = addr_q;
        romd_d  = romd_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_COLLECT;
                ready_d = 1'b1;
            end
            S_COLLECT: begin
                ready_d = 1'b1;
                if (coef_valid_i && ready_q) begin
                    coef_d[cnt_q] = coef_in_i;
                    if (cnt_q == CNT_LAST) begin
                        // First write (address 0, always zero) is launched
                        // straight from the final transfer.
                        cnt_d   = '0;
                        state_d = S_WRITE;
                        ready_d = 1'b0;
                        cload_d = 1'b1;
                        cen_d   = 1'b0;
                        wen_d   = 1'b0;
                        addr_d  = '0;
                        romd_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cload_d = 1'b1;
                    cen_d   = 1'b0;
                    wen_d   = 1'b0;
                    addr_d  = next_addr;
                    romd_d  = next_sum;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            cload_q <= 1'b0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            addr_q  <= '0;
            romd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            cload_q <= cload_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            romd_q  <= romd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < NTAPS; i++) begin
                coef_q[i] <= coef_d[i];
            end
        end
    end

    assign coef_ready_o = ready_q;
    assign cload_o      = cload_q;
    assign rom_cen_o    = cen_q;
    assign rom_wen_o    = wen_q;
    assign rom_addr_o   = addr_q;
    assign rom_d_o      = romd_q;
    assign busy_o       = busy_q;
    assign load_done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_da_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_da_rom_loader
//  Purpose  : Self-checking bench for da_rom_loader. Expected ROM words are
//             computed from the coefficient set with plain integer sums.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_da_rom_loader;

    logic       clk;
    logic       resetn;
    logic [7:0] coef_in;
    logic       coef_valid;
    logic       coef_ready_o;
    logic       cload_o;
    logic       rom_cen_o;
    logic       rom_wen_o;
    logic [3:0] rom_addr_o;
    logic [9:0] rom_d_o;
    logic       busy_o;
    logic       load_done_o;

    logic [5:0] ctl;
    assign ctl = {rom_cen_o, rom_wen_o, cload_o, busy_o, coef_ready_o, load_done_o};

    int n_checks = 0;
    int n_pass   = 0;

    logic signed [7:0] cur [4];
    logic [9:0]        cap [16];

    da_rom_loader #(.NTAPS(4), .CW(8), .DW(10)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .coef_in_i    (coef_in),
        .coef_valid_i (coef_valid),
        .coef_ready_o (coef_ready_o),
        .cload_o      (cload_o),
        .rom_cen_o    (rom_cen_o),
        .rom_wen_o    (rom_wen_o),
        .rom_addr_o   (rom_addr_o),
        .rom_d_o      (rom_d_o),
        .busy_o       (busy_o),
        .load_done_o  (load_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM word for address a: integer sum of the selected coefficients.
    function automatic logic [9:0] model_word(input int a);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            if (((a >> i) & 1) == 1) s = s + int'(cur[i]);
        end
        return s[9:0];
    endfunction

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
        cur[0] = 8'(c0); cur[1] = 8'(c1); cur[2] = 8'(c2); cur[3] = 8'(c3);
    endtask

    task automatic rand_coefs();
        for (int i = 0; i < 4; i++) cur[i] = 8'($urandom);
    endtask

    // gap < 0: random 0..3 idle cycles between coefficients.
    // hold: keep coef_valid high with junk data through WRITE/DONE/IDLE.
    // abort_at: address at which resetn is asserted (-1 for none).
    task automatic do_load(input int gap, input bit hold, input int abort_at);
        int k, guard, gap_left;
        bit bad;
        k = 0; guard = 0; gap_left = 0;
        while (k < 4 && guard < 400) begin
            @(negedge clk);
            guard++;
            n_checks++;
            if (rom_cen_o !== 1'b1 || cload_o !== 1'b0)
                $display("FAIL collect_no_write: cen=%b cload=%b expected cen=1 cload=0 (k=%0d)",
                         rom_cen_o, cload_o, k);
            else n_pass++;
            if (gap_left > 0) begin
                coef_valid = 1'b0;
                coef_in    = 8'($urandom);
                gap_left--;
            end else begin
                coef_valid = 1'b1;
                coef_in    = cur[k];
                if (coef_ready_o === 1'b1) begin
                    k++;
                    gap_left = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                end
            end
        end
        if (k < 4) begin
            n_checks++;
            $display("FAIL load_timeout: transfers=%0d expected 4", k);
            return;
        end
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            coef_valid = hold;
            coef_in    = hold ? 8'($urandom) : 8'd0;
            n_checks++;
            if (ctl !== 6'b001100)
                $display("FAIL write_ctl a=%0d: {cen,wen,cload,busy,ready,done}=%b expected 001100", a, ctl);
            else n_pass++;
            n_checks++;
            if (rom_addr_o !== 4'(a))
                $display("FAIL write_addr: got %0d expected %0d", rom_addr_o, a);
            else n_pass++;
            n_checks++;
            if (rom_d_o !== model_word(a))
                $display("FAIL write_data a=%0d: got %h expected %h", a, rom_d_o, model_word(a));
            else n_pass++;
            cap[a] = rom_d_o;
            if (a == abort_at) begin
                resetn = 1'b0;
                @(negedge clk);
                n_checks++;
                if ({ctl, rom_addr_o, rom_d_o} !== {6'b110000, 4'd0, 10'd0})
                    $display("FAIL abort_reset: ctl=%b addr=%0d d=%h expected ctl=110000 addr=0 d=000",
                             ctl, rom_addr_o, rom_d_o);
                else n_pass++;
                resetn     = 1'b1;
                coef_valid = 1'b0;
                bad = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (load_done_o !== 1'b0 || rom_cen_o !== 1'b1) bad = 1'b1;
                end
                n_checks++;
                if (bad) $display("FAIL abort_no_done: load_done/cen activity seen, expected none");
                else n_pass++;
                return;
            end
        end
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b110101)
            $display("FAIL done_cycle: {cen,wen,cload,busy,ready,done}=%b expected 110101", ctl);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b110000)
            $display("FAIL idle_cycle: {cen,wen,cload,busy,ready,done}=%b expected 110000", ctl);
        else n_pass++;
        if (!hold) coef_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; coef_valid = 1'b1; coef_in = 8'h5A;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ctl, rom_addr_o, rom_d_o} !== {6'b110000, 4'd0, 10'd0})
            $display("FAIL reset_state: ctl=%b addr=%0d d=%h expected ctl=110000 addr=0 d=000",
                     ctl, rom_addr_o, rom_d_o);
        else n_pass++;
        coef_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b110110)
            $display("FAIL reset_to_collect: ctl=%b expected 110110", ctl);
        else n_pass++;
    endtask

    task automatic test_known();
        set_coefs(1, 2, 3, 4);
        do_load(0, 1'b0, -1);
        n_checks++;
        if ({cap[0], cap[1], cap[5], cap[10], cap[15]} !== {10'd0, 10'd1, 10'd4, 10'd6, 10'd10})
            $display("FAIL known_words: a0=%0d a1=%0d a5=%0d a10=%0d a15=%0d expected 0 1 4 6 10",
                     cap[0], cap[1], cap[5], cap[10], cap[15]);
        else n_pass++;
    endtask

    task automatic test_min_coef();
        set_coefs(-128, -128, -128, -128);
        do_load(-1, 1'b0, -1);
        n_checks++;
        if (cap[15] !== 10'h200 || cap[3] !== 10'h300)
            $display("FAIL min_coef: a15=%h a3=%h expected 200 300", cap[15], cap[3]);
        else n_pass++;
    endtask

    task automatic test_gaps();
        rand_coefs();
        do_load(3, 1'b0, -1);
    endtask

    task automatic test_hold_valid();
        rand_coefs();
        do_load(-1, 1'b1, -1);
        rand_coefs();
        do_load(0, 1'b0, -1);
    endtask

    task automatic test_abort();
        rand_coefs();
        do_load(0, 1'b0, 7);
        rand_coefs();
        do_load(-1, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        set_coefs(1, 2, 3, 4);
        do_load(0, 1'b0, -1);
        set_coefs(4, 3, 2, 1);
        do_load(0, 1'b0, -1);
        n_checks++;
        if (cap[15] !== 10'd10 || cap[1] !== 10'd4)
            $display("FAIL back_to_back: a15=%0d a1=%0d expected 10 4", cap[15], cap[1]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) begin
            rand_coefs();
            do_load(-1, n[0], -1);
        end
    endtask

    initial begin
        resetn = 1'b0; coef_valid = 1'b0; coef_in = 8'd0;
        test_reset();
        test_known();
        test_min_coef();
        test_gaps();
        test_hold_valid();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
